// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: arbitrates the frame-buffer write port among trail, overlay and screen-clear (`FB_ARB_BURST_LIMIT_EN` caps burst length).
// Latency: a grant follows req by 1 cycle from IDLE, and accepted words reach fb_* 1 cycle later.
// Backpressure: a requester holds its word until req&&gnt, bursts are not interrupted, and round-robin applies at burst ends.
module fb_write_arbiter #(
   parameter int unsigned       ADDR_W     = 20,
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       FB_WORDS   = 76800,
   parameter logic [DATA_W-1:0] CLEAR_DATA = '0,
   parameter int unsigned       MAX_BURST  = 64
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              trail_req,
   input  logic [ADDR_W-1:0] trail_addr,
   input  logic [DATA_W-1:0] trail_data,
   input  logic              trail_last,
   output logic              trail_gnt,
   input  logic              ovl_req,
   input  logic [ADDR_W-1:0] ovl_addr,
   input  logic [DATA_W-1:0] ovl_data,
   input  logic              ovl_last,
   output logic              ovl_gnt,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              burst_err,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data
);

   typedef enum logic [1:0] {ST_IDLE, ST_TRAIL, ST_OVL, ST_CLEAR} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dat;
   } fb_word_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);

   state_t            state;
   state_t            state_nxt;
   logic              clear_pend;
   logic              clear_req;
   logic              rr_last;      // 1: overlay was served last, so trail wins the next tie
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_last;
   logic              done_q;
   logic              acc_trail;
   logic              acc_ovl;
   logic              burst_hit;
   logic              wr_vld_nxt;
   fb_word_t          wr_nxt;

   assign clear_busy = clear_pend | (state == ST_CLEAR) | done_q;
   assign clear_done = done_q;
   assign clear_req  = clear_start & ~clear_busy;

   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (clear_pend || clear_req)  state_nxt = ST_CLEAR;
            else if (trail_req && ovl_req) state_nxt = rr_last ? ST_TRAIL : ST_OVL;
            else if (trail_req)            state_nxt = ST_TRAIL;
            else if (ovl_req)              state_nxt = ST_OVL;
         end
         ST_TRAIL: if (!trail_req || trail_last || burst_hit) state_nxt = ST_IDLE;
         ST_OVL:   if (!ovl_req || ovl_last || burst_hit)     state_nxt = ST_IDLE;
         ST_CLEAR: if (clr_cnt == CLR_LAST)                   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      trail_gnt  = (state == ST_TRAIL);
      ovl_gnt    = (state == ST_OVL);
      acc_trail  = trail_gnt & trail_req;
      acc_ovl    = ovl_gnt & ovl_req;
      clr_last   = (state == ST_CLEAR) && (clr_cnt == CLR_LAST);
      wr_vld_nxt = 1'b0;
      wr_nxt     = '{addr: clr_cnt, dat: CLEAR_DATA};
      if (acc_trail) begin
         wr_vld_nxt = 1'b1;
         wr_nxt     = '{addr: trail_addr, dat: trail_data};
      end else if (acc_ovl) begin
         wr_vld_nxt = 1'b1;
         wr_nxt     = '{addr: ovl_addr, dat: ovl_data};
      end else if (state == ST_CLEAR) begin
         wr_vld_nxt = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         clear_pend <= 1'b0;
         rr_last    <= 1'b1;
         clr_cnt    <= '0;
         done_q     <= 1'b0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
      end else begin
         // Entering CLEAR consumes the request, including one arriving that same cycle.
         if (state != ST_CLEAR && state_nxt == ST_CLEAR) clear_pend <= 1'b0;
         else if (clear_req)                              clear_pend <= 1'b1;

         if (state == ST_TRAIL && state_nxt == ST_IDLE)    rr_last <= 1'b0;
         else if (state == ST_OVL && state_nxt == ST_IDLE) rr_last <= 1'b1;

         if (state == ST_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);

         done_q <= clr_last;
         fb_we  <= wr_vld_nxt;
         if (wr_vld_nxt) begin
            fb_addr <= wr_nxt.addr;
            fb_data <= wr_nxt.dat;
         end
      end
   end

`ifdef FB_ARB_BURST_LIMIT_EN
   localparam int unsigned BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   logic [BC_W-1:0] burst_cnt;
   logic            burst_err_q;
   logic            acc_any;
   logic            acc_last;

   always_comb begin
      acc_any   = acc_trail | acc_ovl;
      acc_last  = acc_trail ? trail_last : ovl_last;
      burst_hit = acc_any && !acc_last && (burst_cnt == BC_W'(MAX_BURST - 1));
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         burst_cnt   <= '0;
         burst_err_q <= 1'b0;
      end else begin
         if (state_nxt == ST_IDLE) burst_cnt <= '0;
         else if (acc_any)         burst_cnt <= burst_cnt + BC_W'(1);
         if (burst_hit) burst_err_q <= 1'b1;
      end
   end

   assign burst_err = burst_err_q;
`else
   assign burst_hit = 1'b0;
   assign burst_err = 1'b0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed + randomized bench for fb_write_arbiter; expected writes are built from the arbitration rules into a scoreboard queue.
module tb_fb_write_arbiter;
   localparam int AW  = 20;
   localparam int DW  = 16;
   localparam int FBW = 600;
   localparam int MB  = 64;
   localparam logic [DW-1:0] CLR = 16'h0000;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          trail_req, trail_last, trail_gnt;
   logic [AW-1:0] trail_addr;
   logic [DW-1:0] trail_data;
   logic          ovl_req, ovl_last, ovl_gnt;
   logic [AW-1:0] ovl_addr;
   logic [DW-1:0] ovl_data;
   logic          clear_start, clear_busy, clear_done, burst_err;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data;

   always #5 Clk = ~Clk;

   fb_write_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .CLEAR_DATA(CLR), .MAX_BURST(MB)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .trail_req(trail_req), .trail_addr(trail_addr), .trail_data(trail_data),
      .trail_last(trail_last), .trail_gnt(trail_gnt),
      .ovl_req(ovl_req), .ovl_addr(ovl_addr), .ovl_data(ovl_data),
      .ovl_last(ovl_last), .ovl_gnt(ovl_gnt),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .burst_err(burst_err), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } wd_t;

   wd_t              t_q[$];
   wd_t              o_q[$];
   logic [AW+DW-1:0] exp_q[$];
   bit               t_en, o_en;
   int               tests_run, tests_failed, cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   function automatic wd_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
      wd_t w;
      w.addr = a; w.data = d; w.last = l;
      return w;
   endfunction

   task automatic drive();
      trail_req  = t_en && (t_q.size() > 0);
      trail_addr = (t_q.size() > 0) ? t_q[0].addr : '0;
      trail_data = (t_q.size() > 0) ? t_q[0].data : '0;
      trail_last = (t_q.size() > 0) ? t_q[0].last : 1'b0;
      ovl_req    = o_en && (o_q.size() > 0);
      ovl_addr   = (o_q.size() > 0) ? o_q[0].addr : '0;
      ovl_data   = (o_q.size() > 0) ? o_q[0].data : '0;
      ovl_last   = (o_q.size() > 0) ? o_q[0].last : 1'b0;
   endtask

   // One clock: retire accepted words, score any write, present the next words.
   task automatic tick();
      bit at, ao;
      logic [AW+DW-1:0] e;
      at = trail_req && trail_gnt;
      ao = ovl_req && ovl_gnt;
      @(posedge Clk);
      #1;
      cyc++;
      if (at && t_q.size() > 0) void'(t_q.pop_front());
      if (ao && o_q.size() > 0) void'(o_q.pop_front());
      if (fb_we) begin
         if (exp_q.size() == 0) chk("unexpected_write", {fb_we, fb_addr, fb_data}, '0);
         else begin
            e = exp_q.pop_front();
            chk("write_word", {fb_addr, fb_data}, e);
         end
      end
      drive();
   endtask

   task automatic do_reset();
      Reset = 1'b1; clear_start = 1'b0;
      t_q.delete(); o_q.delete(); exp_q.delete();
      t_en = 1'b1; o_en = 1'b1;
      drive();
      tick(); tick();
      Reset = 1'b0;
   endtask

   task automatic run_until_empty(input int max, input string tag);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < max) begin tick(); n++; end
      chk({tag, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic watch(input int n, input int pulse_at, input string tag,
                        output int dcnt, output int dcyc);
      bit prev;
      dcnt = 0; dcyc = -1; prev = 1'b0;
      for (int i = 0; i < n; i++) begin
         clear_start = (i == pulse_at);
         tick();
         if (prev) chk({tag, "_busy_fall"}, clear_busy, 0);
         prev = clear_done;
         if (clear_done) begin
            dcnt++; dcyc = cyc;
            chk({tag, "_done_align"}, {fb_we, fb_addr}, {1'b1, AW'(FBW - 1)});
         end
         if (trail_gnt) chk({tag, "_gnt_while_busy"}, clear_busy, 0);
      end
      clear_start = 1'b0;
   endtask

   initial begin
      int s, dcnt, dcyc, n_b, len, ti, oi, bt, bo;
      bit m_trail_next;
      int tl[$];
      int ol[$];
      wd_t tw[$];
      wd_t ow[$];
      logic [DW-1:0] d;

      tests_run = 0; tests_failed = 0; cyc = 0;

      // Reset values
      do_reset();
      chk("rst_trail_gnt", trail_gnt, 0);
      chk("rst_ovl_gnt", ovl_gnt, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_burst_err", burst_err, 0);

      // Single trail burst 0x100..0x103
      for (int i = 0; i < 4; i++) begin
         d = DW'($urandom);
         t_q.push_back(mk(AW'(32'h100 + i), d, i == 3));
         add_exp(AW'(32'h100 + i), d);
      end
      drive();
      chk("t1_gnt_before", trail_gnt, 0);
      tick();
      chk("t1_gnt_after_1", trail_gnt, 1);
      chk("t1_no_write_yet", fb_we, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_we_burst", fb_we, 1);
      end
      chk("t1_gnt_released", trail_gnt, 0);
      tick();
      chk("t1_we_after", fb_we, 0);
      chk("t1_all_written", exp_q.size(), 0);

      // Round robin with 2-word bursts from both sides
      do_reset();
      for (int r = 0; r < 3; r++) begin
         wd_t a0, a1, b0, b1;
         a0 = mk(AW'($urandom), DW'($urandom), 1'b0); a1 = mk(AW'($urandom), DW'($urandom), 1'b1);
         b0 = mk(AW'($urandom), DW'($urandom), 1'b0); b1 = mk(AW'($urandom), DW'($urandom), 1'b1);
         t_q.push_back(a0); t_q.push_back(a1); o_q.push_back(b0); o_q.push_back(b1);
         add_exp(a0.addr, a0.data); add_exp(a1.addr, a1.data);
         add_exp(b0.addr, b0.data); add_exp(b1.addr, b1.data);
      end
      drive();
      for (int k = 0; k < 18; k++) begin
         tick();
         chk("t2_trail_gnt", trail_gnt, ((k % 3) < 2) && ((k / 3) % 2 == 0));
         chk("t2_ovl_gnt", ovl_gnt, ((k % 3) < 2) && ((k / 3) % 2 == 1));
      end
      run_until_empty(5, "t2");

      // Clear requested during a 3-word overlay burst, trail waiting
      for (int i = 0; i < 3; i++) begin
         d = DW'($urandom);
         o_q.push_back(mk(AW'(32'h2000 + i), d, i == 2));
         add_exp(AW'(32'h2000 + i), d);
      end
      drive();
      tick();
      chk("t3_ovl_gnt", ovl_gnt, 1);
      for (int a = 0; a < FBW; a++) add_exp(AW'(a), CLR);
      for (int i = 0; i < 2; i++) begin
         d = DW'($urandom);
         t_q.push_back(mk(AW'(32'h3000 + i), d, i == 1));
         add_exp(AW'(32'h3000 + i), d);
      end
      s = cyc;
      clear_start = 1'b1;
      drive();
      tick();
      clear_start = 1'b0;
      chk("t3_busy_pending", clear_busy, 1);
      chk("t3_ovl_keeps_gnt", ovl_gnt, 1);
      watch(FBW + 30, -1, "t3", dcnt, dcyc);
      chk("t3_done_count", dcnt, 1);
      chk("t3_done_cycle", dcyc - s, FBW + 4);
      chk("t3_all_written", exp_q.size(), 0);

      // Reset mid-clear at clr_cnt=500, then a full clear with an ignored second start
      do_reset();
      for (int a = 0; a < 500; a++) add_exp(AW'(a), CLR);
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("t4_busy_n1", clear_busy, 1);
      chk("t4_we_n1", fb_we, 0);
      for (int i = 0; i < 500; i++) tick();
      chk("t4_partial_written", exp_q.size(), 0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("t4_we_after_reset", fb_we, 0);
      chk("t4_busy_after_reset", clear_busy, 0);
      chk("t4_done_after_reset", clear_done, 0);
      tick();
      chk("t4_we_idle", fb_we, 0);
      for (int a = 0; a < FBW; a++) add_exp(AW'(a), CLR);
      s = cyc;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("t4b_busy_n1", clear_busy, 1);
      watch(FBW + 10, 100, "t4b", dcnt, dcyc);
      chk("t4b_done_count", dcnt, 1);
      chk("t4b_done_cycle", dcyc - s, FBW + 1);
      chk("t4b_all_written", exp_q.size(), 0);
      chk("t4b_busy_end", clear_busy, 0);

      // Owner drops req after 2 of 5 words
      do_reset();
      for (int i = 0; i < 5; i++) begin
         d = DW'($urandom);
         t_q.push_back(mk(AW'(32'h400 + i), d, i == 4));
         if (i < 2) add_exp(AW'(32'h400 + i), d);
      end
      for (int i = 0; i < 2; i++) begin
         d = DW'($urandom);
         o_q.push_back(mk(AW'(32'h500 + i), d, i == 1));
         add_exp(AW'(32'h500 + i), d);
      end
      drive();
      tick();
      chk("t5_trail_first", trail_gnt, 1);
      tick(); tick();
      t_en = 1'b0;
      drive();
      tick();
      chk("t5_trail_gnt_drop", trail_gnt, 0);
      chk("t5_ovl_not_yet", ovl_gnt, 0);
      tick();
      chk("t5_ovl_gnt_2later", ovl_gnt, 1);
      run_until_empty(10, "t5");
      tick(); tick(); tick();
      chk("t5_trail_left", t_q.size(), 3);

      // Long trail burst without early last
      do_reset();
      for (int i = 0; i < 70; i++) begin
         d = DW'($urandom);
         t_q.push_back(mk(AW'(32'h8000 + i), d, i == 69));
`ifdef FB_ARB_BURST_LIMIT_EN
         if (i < MB) add_exp(AW'(32'h8000 + i), d);
`else
         add_exp(AW'(32'h8000 + i), d);
`endif
      end
      drive();
      for (int i = 0; i < MB + 1; i++) tick();
`ifdef FB_ARB_BURST_LIMIT_EN
      chk("t6_gnt_forced_off", trail_gnt, 0);
      chk("t6_burst_err_set", burst_err, 1);
      t_en = 1'b0;
      drive();
      run_until_empty(5, "t6");
      tick(); tick(); tick();
      chk("t6_burst_err_sticky", burst_err, 1);
      do_reset();
      chk("t6_burst_err_cleared", burst_err, 0);
`else
      chk("t6_gnt_continues", trail_gnt, 1);
      run_until_empty(20, "t6");
      chk("t6_gnt_end", trail_gnt, 0);
      chk("t6_no_burst_err", burst_err, 0);
`endif

      // Randomized bursts from both sides against a burst-level round-robin model
      do_reset();
      m_trail_next = 1'b1;
      for (int it = 0; it < 4; it++) begin
         tl.delete(); ol.delete(); tw.delete(); ow.delete();
         n_b = $urandom_range(1, 4);
         for (int b = 0; b < n_b; b++) begin
            len = $urandom_range(1, 6);
            tl.push_back(len);
            for (int k = 0; k < len; k++) tw.push_back(mk(AW'($urandom), DW'($urandom), k == len - 1));
         end
         n_b = $urandom_range(1, 4);
         for (int b = 0; b < n_b; b++) begin
            len = $urandom_range(1, 6);
            ol.push_back(len);
            for (int k = 0; k < len; k++) ow.push_back(mk(AW'($urandom), DW'($urandom), k == len - 1));
         end
         foreach (tw[i]) t_q.push_back(tw[i]);
         foreach (ow[i]) o_q.push_back(ow[i]);
         ti = 0; oi = 0; bt = 0; bo = 0;
         while (bt < tl.size() || bo < ol.size()) begin
            if ((m_trail_next && bt < tl.size()) || bo >= ol.size()) begin
               for (int k = 0; k < tl[bt]; k++) begin add_exp(tw[ti].addr, tw[ti].data); ti++; end
               bt++; m_trail_next = 1'b0;
            end else begin
               for (int k = 0; k < ol[bo]; k++) begin add_exp(ow[oi].addr, ow[oi].data); oi++; end
               bo++; m_trail_next = 1'b1;
            end
         end
         drive();
         run_until_empty(200, "rand");
         tick(); tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
